ram_port_arbiter: RTL and testbench

//  Shares one port of a dual-port block RAM between two requesters on a single clock.

---
 rtl/ram_port_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one port of a dual-port block RAM between two requesters on one clock.
//   Arbitration is round-robin (PRIO_MODE=0) or fixed priority with requester 0
//   high (PRIO_MODE=1), where requester 1 is forced through after MAX_WAIT losses.
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   rX_req/we/addr/wdata    requester X access, held stable until rX_gnt
//   rX_gnt                  combinational accept for this cycle
//   rX_rvalid, rX_rdata     read return two cycles after the grant
//   ram_enable/wren/address/data  RAM port command, one cycle after the grant
//   ram_q                   RAM registered read data (1-cycle latency)
module ram_port_arbiter #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned MAX_WAIT  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              ram_enable,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic FIXED_PRIO = (PRIO_MODE != 0);
    localparam logic FORCE_EN   = (MAX_WAIT != 0);

    logic             last_winner;
    logic [CNT_W-1:0] wait_cnt;
    logic             p1_valid;
    logic             p1_port;

    logic              win_r1_c;
    logic              gnt_any_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    // Contention winner: alternate in round-robin, else r0 unless r1 has starved
    always_comb begin
        win_r1_c = 1'b0;
        if (!FIXED_PRIO) begin
            win_r1_c = (last_winner == 1'b0);
        end else begin
            win_r1_c = FORCE_EN && (wait_cnt == WAIT_LIMIT);
        end
    end

    // Grant decode: depends only on request levels and registered arbiter state
    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (!reset) begin
            if (r0_req && r1_req) begin
                r0_gnt = !win_r1_c;
                r1_gnt = win_r1_c;
            end else begin
                r0_gnt = r0_req;
                r1_gnt = r1_req;
            end
        end
    end

    // Granted request mux
    always_comb begin
        gnt_any_c   = r0_gnt | r1_gnt;
        sel_we_c    = r1_gnt ? r1_we    : r0_we;
        sel_addr_c  = r1_gnt ? r1_addr  : r0_addr;
        sel_wdata_c = r1_gnt ? r1_wdata : r0_wdata;
    end

    // Command stage, pending-read pipeline and arbiter state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_enable  <= 1'b0;
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            p1_valid    <= 1'b0;
            p1_port     <= 1'b0;
            r0_rvalid   <= 1'b0;
            r1_rvalid   <= 1'b0;
            last_winner <= 1'b1;
            wait_cnt    <= '0;
        end else begin
            ram_enable <= gnt_any_c;
            ram_wren   <= gnt_any_c & sel_we_c;
            // Address/data hold their last values while idle
            if (gnt_any_c) begin
                ram_address <= sel_addr_c;
                ram_data    <= sel_wdata_c;
                last_winner <= r1_gnt;
            end
            // Port id travels with each read so alternating grants return correctly
            p1_valid  <= gnt_any_c & ~sel_we_c;
            p1_port   <= r1_gnt;
            r0_rvalid <= p1_valid & ~p1_port;
            r1_rvalid <= p1_valid &  p1_port;
            // Requester 1 starvation counter, saturating at the force threshold
            if (!r1_req || r1_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // Read data is shared; consumers qualify it with their rvalid
    assign r0_rdata = ram_q;
    assign r1_rdata = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: three instances (round-robin, fixed MAX_WAIT=4,
// fixed MAX_WAIT=0) driven in lock-step against a transaction-level model.
module tb_ram_port_arbiter;

    typedef struct packed {
        logic        v;
        logic        port;
        logic        we;
        logic [10:0] a;
        logic [7:0]  d;
        logic [7:0]  rd;
    } hist_t;

    logic clock;
    logic reset;

    logic        req    [3][2];
    logic        we     [3][2];
    logic [10:0] addr   [3][2];
    logic [7:0]  wdata  [3][2];
    logic        gnt    [3][2];
    logic        rvalid [3][2];
    logic [7:0]  rdata  [3][2];
    logic        ram_en [3];
    logic        ram_wr [3];
    logic [10:0] ram_a  [3];
    logic [7:0]  ram_d  [3];
    logic [7:0]  ram_q  [3];

    // Block RAM behaviour behind each instance
    logic [7:0] ram_mem [3][2048];
    bit         ram_w   [3][2048];

    // Reference model state
    logic [7:0] mm  [3][2048];
    bit         mw  [3][2048];
    hist_t      h1  [3];
    hist_t      h2  [3];
    logic       lw  [3];
    int         lost[3];
    logic [10:0] la [3];
    logic [7:0]  ld [3];
    logic       mg  [3][2];
    logic       og  [3][2];

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.ADDR_W(11), .DATA_W(8), .PRIO_MODE(0), .MAX_WAIT(8)) u_rr (
        .clock(clock), .reset(reset),
        .r0_req(req[0][0]), .r0_we(we[0][0]), .r0_addr(addr[0][0]), .r0_wdata(wdata[0][0]),
        .r0_gnt(gnt[0][0]), .r0_rvalid(rvalid[0][0]), .r0_rdata(rdata[0][0]),
        .r1_req(req[0][1]), .r1_we(we[0][1]), .r1_addr(addr[0][1]), .r1_wdata(wdata[0][1]),
        .r1_gnt(gnt[0][1]), .r1_rvalid(rvalid[0][1]), .r1_rdata(rdata[0][1]),
        .ram_enable(ram_en[0]), .ram_wren(ram_wr[0]), .ram_address(ram_a[0]),
        .ram_data(ram_d[0]), .ram_q(ram_q[0]));

    ram_port_arbiter #(.ADDR_W(11), .DATA_W(8), .PRIO_MODE(1), .MAX_WAIT(4)) u_fx4 (
        .clock(clock), .reset(reset),
        .r0_req(req[1][0]), .r0_we(we[1][0]), .r0_addr(addr[1][0]), .r0_wdata(wdata[1][0]),
        .r0_gnt(gnt[1][0]), .r0_rvalid(rvalid[1][0]), .r0_rdata(rdata[1][0]),
        .r1_req(req[1][1]), .r1_we(we[1][1]), .r1_addr(addr[1][1]), .r1_wdata(wdata[1][1]),
        .r1_gnt(gnt[1][1]), .r1_rvalid(rvalid[1][1]), .r1_rdata(rdata[1][1]),
        .ram_enable(ram_en[1]), .ram_wren(ram_wr[1]), .ram_address(ram_a[1]),
        .ram_data(ram_d[1]), .ram_q(ram_q[1]));

    ram_port_arbiter #(.ADDR_W(11), .DATA_W(8), .PRIO_MODE(1), .MAX_WAIT(0)) u_fx0 (
        .clock(clock), .reset(reset),
        .r0_req(req[2][0]), .r0_we(we[2][0]), .r0_addr(addr[2][0]), .r0_wdata(wdata[2][0]),
        .r0_gnt(gnt[2][0]), .r0_rvalid(rvalid[2][0]), .r0_rdata(rdata[2][0]),
        .r1_req(req[2][1]), .r1_we(we[2][1]), .r1_addr(addr[2][1]), .r1_wdata(wdata[2][1]),
        .r1_gnt(gnt[2][1]), .r1_rvalid(rvalid[2][1]), .r1_rdata(rdata[2][1]),
        .ram_enable(ram_en[2]), .ram_wren(ram_wr[2]), .ram_address(ram_a[2]),
        .ram_data(ram_d[2]), .ram_q(ram_q[2]));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Power-up RAM contents; 0x123 holds 0xA5
    function automatic logic [7:0] init_val(input logic [10:0] a);
        if (a == 11'h123) return 8'hA5;
        return 8'(a ^ (a >> 3));
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (ram_en[k]) begin
                if (ram_wr[k]) begin
                    ram_mem[k][ram_a[k]] <= ram_d[k];
                    ram_w[k][ram_a[k]]   <= 1'b1;
                end else begin
                    ram_q[k] <= ram_w[k][ram_a[k]] ? ram_mem[k][ram_a[k]] : init_val(ram_a[k]);
                end
            end
        end
    end

    function automatic int mode_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic int maxw_of(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 4 : 0);
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst%0d: observed %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        h1[i] = '0; h2[i] = '0; lw[i] = 1'b1; lost[i] = 0;
        la[i] = '0; ld[i] = '0; mg[i][0] = 1'b0; mg[i][1] = 1'b0;
    endtask

    // Compare one instance against the model for the current cycle, then advance the model
    task automatic check_inst(input int i);
        logic  e0, e1, win1, exp_rv;
        hist_t cur;
        int    p;
        e0 = 1'b0; e1 = 1'b0; win1 = 1'b0;
        og[i][0] = gnt[i][0];
        og[i][1] = gnt[i][1];
        if (reset) begin
            chk("rst_r0_gnt", i, 32'(gnt[i][0]), 32'(0));
            chk("rst_r1_gnt", i, 32'(gnt[i][1]), 32'(0));
            chk("rst_r0_rvalid", i, 32'(rvalid[i][0]), 32'(0));
            chk("rst_r1_rvalid", i, 32'(rvalid[i][1]), 32'(0));
            chk("rst_ram_enable", i, 32'(ram_en[i]), 32'(0));
            chk("rst_ram_wren", i, 32'(ram_wr[i]), 32'(0));
            chk("rst_ram_address", i, 32'(ram_a[i]), 32'(0));
            chk("rst_ram_data", i, 32'(ram_d[i]), 32'(0));
            model_reset(i);
            return;
        end
        if (req[i][0] && req[i][1]) begin
            if (mode_of(i) == 0) win1 = (lw[i] == 1'b0);
            else win1 = (maxw_of(i) != 0) && (lost[i] >= maxw_of(i));
            e1 = win1;
            e0 = !win1;
        end else begin
            e0 = req[i][0];
            e1 = req[i][1];
        end
        chk("r0_gnt", i, 32'(gnt[i][0]), 32'(e0));
        chk("r1_gnt", i, 32'(gnt[i][1]), 32'(e1));
        chk("ram_enable", i, 32'(ram_en[i]), 32'(h1[i].v));
        chk("ram_wren", i, 32'(ram_wr[i]), 32'(h1[i].v & h1[i].we));
        chk("ram_address", i, 32'(ram_a[i]), 32'(la[i]));
        chk("ram_data", i, 32'(ram_d[i]), 32'(ld[i]));
        for (int q = 0; q < 2; q++) begin
            exp_rv = h2[i].v && !h2[i].we && (int'(h2[i].port) == q);
            chk(q == 0 ? "r0_rvalid" : "r1_rvalid", i, 32'(rvalid[i][q]), 32'(exp_rv));
            if (exp_rv) chk(q == 0 ? "r0_rdata" : "r1_rdata", i, 32'(rdata[i][q]), 32'(h2[i].rd));
        end
        h2[i] = h1[i];
        cur = '0;
        if (e0 || e1) begin
            p = e1 ? 1 : 0;
            cur.v = 1'b1; cur.port = e1; cur.we = we[i][p];
            cur.a = addr[i][p]; cur.d = wdata[i][p];
            if (cur.we) begin
                mm[i][cur.a] = cur.d;
                mw[i][cur.a] = 1'b1;
            end else begin
                cur.rd = mw[i][cur.a] ? mm[i][cur.a] : init_val(cur.a);
            end
            la[i] = cur.a; ld[i] = cur.d; lw[i] = e1;
        end
        h1[i] = cur;
        if (req[i][1] && !e1) lost[i] = (lost[i] < maxw_of(i)) ? lost[i] + 1 : lost[i];
        else lost[i] = 0;
        mg[i][0] = e0;
        mg[i][1] = e1;
    endtask

    task automatic step();
        @(negedge clock);
        for (int i = 0; i < 3; i++) check_inst(i);
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input int p, input logic r, input logic w,
                           input logic [10:0] a, input logic [7:0] d);
        req[i][p] = r; we[i][p] = w; addr[i][p] = a; wdata[i][p] = d;
    endtask

    // Hold an unserved request; otherwise maybe present a new random access
    task automatic renew(input int i, input int p, input int pct_req, input int pct_we,
                         input logic [10:0] amask);
        if (req[i][p] && !mg[i][p]) return;
        req[i][p]   = ($urandom_range(99) < pct_req);
        we[i][p]    = ($urandom_range(99) < pct_we);
        addr[i][p]  = 11'($urandom) & amask;
        wdata[i][p] = 8'($urandom);
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++)
            for (int p = 0; p < 2; p++) set_req(i, p, 1'b0, 1'b0, 11'h0, 8'h0);
    endtask

    int first_r1;
    int r1_cnt2;

    initial begin
        reset = 1'b1;
        idle_all();
        for (int i = 0; i < 3; i++) model_reset(i);
        step();
        step();
        reset = 1'b0;
        step();

        // Single read of preloaded 0x123 on r0
        for (int i = 0; i < 3; i++) set_req(i, 0, 1'b1, 1'b0, 11'h123, 8'h00);
        step();
        idle_all();
        repeat (3) step();

        // r1 write 0x3C @0x010 followed by read of the same address
        for (int i = 0; i < 3; i++) set_req(i, 1, 1'b1, 1'b1, 11'h010, 8'h3C);
        step();
        for (int i = 0; i < 3; i++) set_req(i, 1, 1'b1, 1'b0, 11'h010, 8'h00);
        step();
        idle_all();
        repeat (3) step();

        // Continuous reads on both ports; r1 starts from a cleared wait state
        first_r1 = -1;
        r1_cnt2  = 0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 3; i++) begin
                renew(i, 0, 100, 0, 11'h7FF);
                renew(i, 1, 100, 0, 11'h7FF);
            end
            step();
            if (og[1][1] && first_r1 < 0) first_r1 = k;
            if (og[2][1]) r1_cnt2++;
        end
        chk("fixed_force_cycle", 1, 32'(first_r1), 32'(4));
        chk("never_force_r1", 2, 32'(r1_cnt2), 32'(0));
        for (int i = 0; i < 3; i++) begin
            set_req(i, 0, 1'b0, 1'b0, 11'h0, 8'h0);
            renew(i, 1, 100, 0, 11'h7FF);
        end
        step();
        chk("r1_gnt_after_r0_drop", 2, 32'(og[2][1]), 32'(1));
        idle_all();
        repeat (3) step();

        // Reset while a read is in flight
        for (int i = 0; i < 3; i++) set_req(i, 0, 1'b1, 1'b0, 11'h123, 8'h00);
        step();
        idle_all();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            set_req(i, 0, 1'b1, 1'b0, 11'h005, 8'h00);
            set_req(i, 1, 1'b1, 1'b0, 11'h006, 8'h00);
        end
        step();
        chk("post_reset_contention", 0, 32'(og[0][0]), 32'(1));

        // Random mixed traffic over a small address window
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                renew(i, 0, 60, 40, 11'h00F);
                renew(i, 1, 60, 40, 11'h00F);
            end
            step();
        end
        idle_all();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
